// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between two control units and the shared-ALU scheduler.
// master = requester side, slave = scheduler side.
interface alu_rr_scheduler_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [1:0] req0_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [1:0] req1_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_cout;
  logic       busy;
  logic [7:0] ops_done;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, busy, ops_done
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, busy, ops_done
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Shares one alu_4bit between two valid/ready requesters with round-robin or fixed-priority
// arbitration; operands are held on the ALU for EXEC_CYCLES cycles, then returned per channel.
//
// state | meaning
// IDLE  | waiting for a request; req_ready is the one-hot grant
// EXEC  | latched operands driven on the ALU, exec counter running down
// RESP  | result held, rsp_valid[id] high until rsp_ready[id]

module alu_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] tt,
  output logic [7:0] result,
  output logic       cout
);
  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {4'b0000, a} * {4'b0000, b};

  // add/sub are nibble-wide with carry/borrow on cout; mul fills the whole byte
  always_comb begin
    result = 8'h00;
    cout   = 1'b0;
    case (tt)
      2'b00: begin
        result = {4'b0000, sum[3:0]};
        cout   = sum[4];
      end
      2'b01: begin
        result = {4'b0000, diff[3:0]};
        cout   = diff[4];
      end
      2'b10:   result = prod;
      default: result = {4'b0000, a & b};
    endcase
  end
endmodule

module alu_rr_scheduler #(
  parameter int EXEC_CYCLES = 1,
  parameter bit RR_ENABLE   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  alu_rr_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       prio;
  logic       id_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [3:0] exec_cnt;
  logic [7:0] result_q;
  logic       cout_q;
  logic [7:0] ops_q;

  logic [1:0] gnt;
  logic [1:0] ready_c;
  logic [1:0] valid_c;
  logic       busy_c;
  logic       accept;
  logic       capture;
  logic       complete;
  logic [3:0] win_a;
  logic [3:0] win_b;
  logic [1:0] win_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_tt;
  logic [7:0] alu_result;
  logic       alu_cout;

  // prio names the channel that wins a tie; it flips to the loser on every accept
  always_comb begin
    if (bus.req_valid == 2'b11)
      gnt = (RR_ENABLE && prio) ? 2'b10 : 2'b01;
    else
      gnt = bus.req_valid;
  end

  assign win_a  = gnt[1] ? bus.req1_a  : bus.req0_a;
  assign win_b  = gnt[1] ? bus.req1_b  : bus.req0_b;
  assign win_op = gnt[1] ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 2'b00;
    valid_c   = 2'b00;
    busy_c    = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        ready_c = gnt;
        if (gnt != 2'b00) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy_c = 1'b1;
        if (exec_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy_c  = 1'b1;
        valid_c = id_q ? 2'b10 : 2'b01;
        if (bus.rsp_ready[id_q]) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 2'd0;
      exec_cnt <= 4'd0;
      result_q <= 8'd0;
      cout_q   <= 1'b0;
      ops_q    <= 8'd0;
    end else begin
      if (accept) begin
        prio     <= ~gnt[1];
        id_q     <= gnt[1];
        a_q      <= win_a;
        b_q      <= win_b;
        op_q     <= win_op;
        exec_cnt <= EXEC_LOAD;
      end else if (state == EXEC && exec_cnt != 4'd0) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      if (capture) begin
        result_q <= alu_result;
        cout_q   <= alu_cout;
      end
      if (complete)
        ops_q <= ops_q + 8'd1;
    end
  end

  // ALU sees only the latched operands, so its inputs hold through IDLE as well
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_tt = op_q;

  alu_4bit u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .tt     (alu_tt),
    .result (alu_result),
    .cout   (alu_cout)
  );

  assign bus.req_ready  = ready_c;
  assign bus.rsp_valid  = valid_c;
  assign bus.rsp_result = result_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.busy       = busy_c;
  assign bus.ops_done   = ops_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench: three scheduler instances (round-robin, fixed priority, EXEC_CYCLES=3)
// with hand-computed expectations checked by immediate assertions.
module tb_alu_rr_scheduler;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   exp_ops;

  alu_rr_scheduler_if b0();
  alu_rr_scheduler_if b1();
  alu_rr_scheduler_if b3();

  alu_rr_scheduler #(.EXEC_CYCLES(1), .RR_ENABLE(1'b1)) u_rr  (.clk(clk), .rst(rst), .bus(b0));
  alu_rr_scheduler #(.EXEC_CYCLES(1), .RR_ENABLE(1'b0)) u_fp  (.clk(clk), .rst(rst), .bus(b1));
  alu_rr_scheduler #(.EXEC_CYCLES(3), .RR_ENABLE(1'b1)) u_ec3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int ch, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    if (ch == 0) begin
      b0.req0_a = a; b0.req0_b = b; b0.req0_op = op;
      b1.req0_a = a; b1.req0_b = b; b1.req0_op = op;
      b0.req_valid[0] = 1'b1; b1.req_valid[0] = 1'b1;
    end else begin
      b0.req1_a = a; b0.req1_b = b; b0.req1_op = op;
      b1.req1_a = a; b1.req1_b = b; b1.req1_op = op;
      b0.req_valid[1] = 1'b1; b1.req_valid[1] = 1'b1;
    end
  endtask

  task automatic clear_valid();
    b0.req_valid = 2'b00;
    b1.req_valid = 2'b00;
  endtask

  // call in IDLE with the request presented; returns with the response showing
  task automatic accept_and_wait(input string tag, input int ch, input logic [7:0] er,
                                 input logic ec);
    int n;
    logic [1:0] oh;
    oh = (ch == 1) ? 2'b10 : 2'b01;
    chk({tag, "_ready"}, b0.req_ready, oh);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) clear_valid();
    end while (b0.rsp_valid == 2'b00 && n < 20);
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_rsp_valid"}, b0.rsp_valid, oh);
    chk({tag, "_result"}, b0.rsp_result, er);
    chk({tag, "_cout"}, b0.rsp_cout, ec);
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    exp_ops = (exp_ops + 1) % 256;
    chk({tag, "_ops_done"}, b0.ops_done, exp_ops);
    chk({tag, "_rsp_cleared"}, b0.rsp_valid, 2'b00);
  endtask

  task automatic run_op(input string tag, input int ch, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] op,
                        input logic [7:0] er, input logic ec);
    @(negedge clk);
    present(ch, a, b, op);
    #1;
    accept_and_wait(tag, ch, er, ec);
    finish_op(tag);
  endtask

  initial begin
    int n;
    int w;
    tests = 0;
    fails = 0;
    exp_ops = 0;
    rst = 1'b1;
    b0.req_valid = 2'b00; b0.rsp_ready = 2'b11;
    b0.req0_a = 4'd0; b0.req0_b = 4'd0; b0.req0_op = 2'd0;
    b0.req1_a = 4'd0; b0.req1_b = 4'd0; b0.req1_op = 2'd0;
    b1.req_valid = 2'b00; b1.rsp_ready = 2'b11;
    b1.req0_a = 4'd0; b1.req0_b = 4'd0; b1.req0_op = 2'd0;
    b1.req1_a = 4'd0; b1.req1_b = 4'd0; b1.req1_op = 2'd0;
    b3.req_valid = 2'b00; b3.rsp_ready = 2'b11;
    b3.req0_a = 4'd0; b3.req0_b = 4'd0; b3.req0_op = 2'd0;
    b3.req1_a = 4'd0; b3.req1_b = 4'd0; b3.req1_op = 2'd0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", b0.req_ready, 2'b00);
    chk("rst_rsp_valid", b0.rsp_valid, 2'b00);
    chk("rst_rsp_result", b0.rsp_result, 8'd0);
    chk("rst_rsp_cout", b0.rsp_cout, 1'b0);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_ops_done", b0.ops_done, 8'd0);
    rst = 1'b0;

    // basic operations, one requester at a time
    run_op("add_5_3", 0, 4'd5, 4'd3, 2'b00, 8'd8, 1'b0);
    run_op("mul_15_15", 1, 4'd15, 4'd15, 2'b10, 8'd225, 1'b0);
    run_op("and_c_3", 1, 4'b1100, 4'b0011, 2'b11, 8'd0, 1'b0);
    run_op("sub_10_3", 0, 4'd10, 4'd3, 2'b01, 8'd7, 1'b0);
    run_op("add_9_8", 0, 4'd9, 4'd8, 2'b00, 8'h01, 1'b1);

    // response back-pressure, waiting requester, wrong-channel rsp_ready
    b0.rsp_ready = 2'b00; b1.rsp_ready = 2'b00;
    @(negedge clk);
    present(1, 4'd6, 4'd7, 2'b00);
    #1;
    accept_and_wait("hold_add", 1, 8'h0d, 1'b0);
    present(0, 4'd3, 4'd5, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", b0.rsp_valid, 2'b10);
      chk("hold_rsp_result", b0.rsp_result, 8'h0d);
      chk("hold_req_ready", b0.req_ready, 2'b00);
      chk("hold_busy", b0.busy, 1'b1);
      chk("hold_ops_done", b0.ops_done, exp_ops);
    end
    b0.rsp_ready = 2'b01; b1.rsp_ready = 2'b01;
    repeat (2) begin
      @(posedge clk); #1;
      chk("wrong_ch_rsp_valid", b0.rsp_valid, 2'b10);
      chk("wrong_ch_ops_done", b0.ops_done, exp_ops);
    end
    b0.rsp_ready = 2'b10; b1.rsp_ready = 2'b10;
    @(posedge clk); #1;
    exp_ops++;
    chk("hold_done_ops", b0.ops_done, exp_ops);
    chk("hold_done_rsp_valid", b0.rsp_valid, 2'b00);
    b0.rsp_ready = 2'b11; b1.rsp_ready = 2'b11;
    accept_and_wait("sub_3_5", 0, 8'h0e, 1'b1);
    finish_op("sub_3_5");

    // reset in the middle of EXEC
    @(negedge clk);
    present(0, 4'd3, 4'd3, 2'b10);
    @(posedge clk); #1;
    clear_valid();
    chk("mid_busy", b0.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", b0.req_ready, 2'b00);
    chk("mid_rst_rsp_valid", b0.rsp_valid, 2'b00);
    chk("mid_rst_result", b0.rsp_result, 8'd0);
    chk("mid_rst_cout", b0.rsp_cout, 1'b0);
    chk("mid_rst_busy", b0.busy, 1'b0);
    chk("mid_rst_ops_done", b0.ops_done, 8'd0);
    exp_ops = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rsp_valid", b0.rsp_valid, 2'b00);
      chk("post_rst_busy", b0.busy, 1'b0);
    end
    @(negedge clk);
    present(0, 4'd1, 4'd1, 2'b00);
    present(1, 4'd2, 4'd2, 2'b00);
    #1;
    accept_and_wait("post_rst_tie", 0, 8'd2, 1'b0);
    finish_op("post_rst_tie");

    // continuous contention: round-robin vs fixed priority
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    present(0, 4'd1, 4'd2, 2'b00);
    present(1, 4'd4, 4'd4, 2'b00);
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (b0.req_ready == 2'b00 && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      chk("rr_grant", b0.req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("fp_grant", b1.req_ready, 2'b01);
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    exp_ops = 4;
    chk("rr_ops_done", b0.ops_done, exp_ops);
    chk("fp_ops_done", b1.ops_done, 8'd4);
    b0.req_valid = 2'b01; b1.req_valid = 2'b01;

    // counter wrap: one op every 3 edges with ch0 held valid
    repeat (753) @(posedge clk);
    #1;
    chk("wrap_ops_255", b0.ops_done, 8'd255);
    repeat (3) @(posedge clk);
    #1;
    clear_valid();
    chk("wrap_ops_0", b0.ops_done, 8'd0);
    chk("wrap_fp_ops_0", b1.ops_done, 8'd0);

    // EXEC_CYCLES = 3 instance: ALU hold window and latency
    @(negedge clk);
    chk("ec3_alu_a_reset", u_ec3.alu_a, 4'd0);
    b3.req1_a = 4'd7; b3.req1_b = 4'd2; b3.req1_op = 2'b00;
    b3.req_valid = 2'b10;
    #1;
    chk("ec3_ready", b3.req_ready, 2'b10);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) b3.req_valid = 2'b00;
      if (n <= 3) begin
        chk("ec3_alu_a", u_ec3.alu_a, 4'd7);
        chk("ec3_alu_b", u_ec3.alu_b, 4'd2);
        chk("ec3_alu_tt", u_ec3.alu_tt, 2'b00);
        chk("ec3_busy", b3.busy, 1'b1);
      end
    end while (b3.rsp_valid == 2'b00 && n < 20);
    chk("ec3_latency", n, 4);
    chk("ec3_rsp_valid", b3.rsp_valid, 2'b10);
    chk("ec3_result", b3.rsp_result, 8'd9);
    @(posedge clk); #1;
    chk("ec3_ops_done", b3.ops_done, 8'd1);
    chk("ec3_alu_a_idle", u_ec3.alu_a, 4'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
